result_ascii_sequencer: RTL and testbench

RESULT_ASCII_SEQUENCER -- requirements
Module: result_ascii_sequencer

---
 rtl/mxv_print_pkg.sv | 38 +++
 rtl/result_ascii_sequencer_bin2bcd.sv | 47 ++++
 rtl/result_ascii_sequencer.sv | 148 ++++++++++++++
 tb/tb_result_ascii_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mxv_print_pkg.sv
// Shared types and constants for the result printer: FSM state encoding,
// ASCII codes, converter length and the shift-and-add-3 step helpers.
package mxv_print_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CONVERT  = 3'd1,
    SEND_H   = 3'd2,
    SEND_T   = 3'd3,
    SEND_O   = 3'd4,
    SEND_SEP = 3'd5,
    SEND_LF  = 3'd6
  } state_e;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [3:0] CONV_CYCLES = 4'd8;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the next shift.
  function automatic logic [11:0] bcd_adjust(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    for (int i = 0; i < 3; i++) begin
      r[i*4 +: 4] = (b[i*4 +: 4] >= 4'd5) ? (b[i*4 +: 4] + 4'd3) : b[i*4 +: 4];
    end
    return r;
  endfunction

  function automatic logic [11:0] bcd_step(input logic [11:0] b, input logic bit_in);
    return (bcd_adjust(b) << 1) | {11'd0, bit_in};
  endfunction

  function automatic logic [7:0] ascii_digit(input logic [3:0] nib);
    return ASCII_ZERO + {4'd0, nib};
  endfunction

endpackage

// File: rtl/result_ascii_sequencer_bin2bcd.sv
// Serial 8-bit binary to 3-digit BCD converter (shift-and-add-3, one bit per
// cycle). bcd carries the finished result during the cycle done is high.
module bin2bcd_serial
  import mxv_print_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic [11:0] bcd,
  output logic        done
);

  logic [7:0]  bin_q;
  logic [11:0] bcd_q;
  logic [11:0] bcd_d;
  logic [3:0]  cnt_q;
  logic        run_q;

  // bcd exposes the post-step value so the caller can latch the final digits
  // on the same edge that ends the eighth conversion cycle.
  assign bcd_d = bcd_step(bcd_q, bin_q[7]);
  assign bcd   = bcd_d;
  assign done  = run_q && (cnt_q == (CONV_CYCLES - 4'd1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bin_q <= 8'd0;
      bcd_q <= 12'd0;
      cnt_q <= 4'd0;
      run_q <= 1'b0;
    end else if (start) begin
      bin_q <= bin;
      bcd_q <= 12'd0;
      cnt_q <= 4'd0;
      run_q <= 1'b1;
    end else if (run_q) begin
      bin_q <= {bin_q[6:0], 1'b0};
      bcd_q <= bcd_d;
      cnt_q <= cnt_q + 4'd1;
      run_q <= !done;
    end else begin
      run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/result_ascii_sequencer.sv
// Prints one accepted result byte as ASCII decimal digits plus a separator or
// CR/LF to a UART-style tx port. Optional LEADING_ZERO_SUPPRESS_EN drops
// leading zero digits (the ones digit is always printed).
module result_ascii_sequencer
  import mxv_print_pkg::*;
#(
  parameter logic [7:0] SEP_CHAR = 8'h2C
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy
);

  state_e      state_q;
  logic        in_ready_q;
  logic        busy_q;
  logic        tx_valid_q;
  logic [7:0]  tx_data_q;
  logic        last_q;
  logic [7:0]  tens_ones_q;

  logic        accept_s;
  logic        tx_fire_s;
  logic        conv_done_s;
  logic [11:0] conv_bcd_s;

  assign accept_s  = (state_q == IDLE) && in_valid && in_ready_q;
  assign tx_fire_s = tx_valid_q && tx_ready;

  // The converter samples in_data on the acceptance edge itself.
  bin2bcd_serial u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (accept_s),
    .bin   (in_data),
    .bcd   (conv_bcd_s),
    .done  (conv_done_s)
  );

  // Sequencer FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      last_q      <= 1'b0;
      tens_ones_q <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            last_q     <= in_last;
            state_q    <= CONVERT;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end else begin
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end
        end
        CONVERT: begin
          if (conv_done_s) begin
            tens_ones_q <= conv_bcd_s[7:0];
            tx_valid_q  <= 1'b1;
`ifdef LEADING_ZERO_SUPPRESS_EN
            if (conv_bcd_s[11:8] != 4'd0) begin
              state_q   <= SEND_H;
              tx_data_q <= ascii_digit(conv_bcd_s[11:8]);
            end else if (conv_bcd_s[7:4] != 4'd0) begin
              state_q   <= SEND_T;
              tx_data_q <= ascii_digit(conv_bcd_s[7:4]);
            end else begin
              state_q   <= SEND_O;
              tx_data_q <= ascii_digit(conv_bcd_s[3:0]);
            end
`else
            state_q   <= SEND_H;
            tx_data_q <= ascii_digit(conv_bcd_s[11:8]);
`endif
          end
        end
        SEND_H: begin
          if (tx_fire_s) begin
            state_q   <= SEND_T;
            tx_data_q <= ascii_digit(tens_ones_q[7:4]);
          end
        end
        SEND_T: begin
          if (tx_fire_s) begin
            state_q   <= SEND_O;
            tx_data_q <= ascii_digit(tens_ones_q[3:0]);
          end
        end
        SEND_O: begin
          if (tx_fire_s) begin
            state_q   <= SEND_SEP;
            tx_data_q <= last_q ? ASCII_CR : SEP_CHAR;
          end
        end
        SEND_SEP: begin
          if (tx_fire_s) begin
            if (last_q) begin
              state_q   <= SEND_LF;
              tx_data_q <= ASCII_LF;
            end else begin
              state_q    <= IDLE;
              tx_valid_q <= 1'b0;
              tx_data_q  <= 8'h00;
              in_ready_q <= 1'b1;
              busy_q     <= 1'b0;
            end
          end
        end
        SEND_LF: begin
          if (tx_fire_s) begin
            state_q    <= IDLE;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          tx_valid_q <= 1'b0;
          tx_data_q  <= 8'h00;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_result_ascii_sequencer.sv
// Self-checking bench for result_ascii_sequencer: byte scoreboard, a vector
// table under random tx back-pressure, and hand sequences for stall and reset.
module tb_result_ascii_sequencer;

`ifdef LEADING_ZERO_SUPPRESS_EN
  localparam bit SUP = 1'b1;
`else
  localparam bit SUP = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;

  logic       bp_en;
  logic       ready_man;
  logic [7:0] exp_b;
  logic [7:0] byte_q [$];
  int         checks;
  int         errors;
  int         xfer_cnt;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         exp_n;
  } vec_t;
  vec_t tbl [8];

  result_ascii_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    tx_ready = bp_en ? 1'($urandom_range(0, 1)) : ready_man;
  end

  always @(negedge clk) begin
    if (reset && tx_valid && tx_ready) begin
      xfer_cnt++;
      checks++;
      if (byte_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_byte: got %02h expected none", tx_data);
      end else begin
        exp_b = byte_q.pop_front();
        if (tx_data !== exp_b) begin
          errors++;
          $display("FAIL tx_byte: got %02h expected %02h", tx_data, exp_b);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: decimal digits by division, not by shift-and-add.
  function automatic void push_model(input logic [7:0] d, input logic l);
    int h, t, o;
    h = int'(d) / 100;
    t = (int'(d) / 10) % 10;
    o = int'(d) % 10;
    if (!SUP || h != 0) byte_q.push_back(8'(8'h30 + h));
    if (!SUP || h != 0 || t != 0) byte_q.push_back(8'(8'h30 + t));
    byte_q.push_back(8'(8'h30 + o));
    if (l) begin
      byte_q.push_back(8'h0D);
      byte_q.push_back(8'h0A);
    end else begin
      byte_q.push_back(8'h2C);
    end
  endfunction

  // Offer one value, then measure cycles from acceptance to first tx_valid.
  task automatic send_value(input logic [7:0] d, input logic l, input logic use_model);
    int w;
    int n;
    w = 0;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    check("in_ready_wait", {31'd0, in_ready}, 32'd1);
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    if (use_model) push_model(d, l);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!tx_valid && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    check("first_valid_cycle", n, 32'd9);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((byte_q.size() != 0 || !in_ready) && w < 300) begin
      @(posedge clk); #1;
      w++;
    end
    check("drain_done", {31'd0, (byte_q.size() == 0 && in_ready)}, 32'd1);
  endtask

  initial begin
    int xs;
    logic stable;
    checks    = 0;
    errors    = 0;
    xfer_cnt  = 0;
    bp_en     = 1'b0;
    ready_man = 1'b1;
    tx_ready  = 1'b1;
    in_data   = 8'd0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    reset     = 1'b0;

    tbl[0] = '{8'd255, 1'b0, 4};
    tbl[1] = '{8'd7,   1'b1, SUP ? 3 : 5};
    tbl[2] = '{8'd0,   1'b0, SUP ? 2 : 4};
    tbl[3] = '{8'd200, 1'b1, 5};
    tbl[4] = '{8'd99,  1'b0, SUP ? 3 : 4};
    tbl[5] = '{8'd10,  1'b1, SUP ? 4 : 5};
    tbl[6] = '{8'd100, 1'b0, 4};
    tbl[7] = '{8'd1,   1'b0, SUP ? 2 : 4};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'h00);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("in_ready_before_edge", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    check("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

    // 255 with literal bytes and in_ready return timing
    byte_q.push_back(8'h32); byte_q.push_back(8'h35);
    byte_q.push_back(8'h35); byte_q.push_back(8'h2C);
    send_value(8'd255, 1'b0, 1'b0);
    check("busy_sending", {31'd0, busy}, 32'd1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("sep_byte_255", {24'd0, tx_data}, 32'h2C);
    check("in_ready_low_at_sep", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    check("in_ready_after_sep", {31'd0, in_ready}, 32'd1);
    drain();

    // 7 with last, literal bytes
    if (SUP) begin
      byte_q.push_back(8'h37);
    end else begin
      byte_q.push_back(8'h30); byte_q.push_back(8'h30); byte_q.push_back(8'h37);
    end
    byte_q.push_back(8'h0D); byte_q.push_back(8'h0A);
    send_value(8'd7, 1'b1, 1'b0);
    drain();

    // 0, literal bytes
    if (!SUP) begin
      byte_q.push_back(8'h30); byte_q.push_back(8'h30);
    end
    byte_q.push_back(8'h30); byte_q.push_back(8'h2C);
    send_value(8'd0, 1'b0, 1'b0);
    drain();

    // Vector table under random back-pressure
    bp_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      xs = xfer_cnt;
      send_value(tbl[i].data, tbl[i].last, 1'b1);
      drain();
      check("byte_count", xfer_cnt - xs, tbl[i].exp_n);
    end
    bp_en = 1'b0;
    @(posedge clk); #1;

    // 105 with a 20-cycle stall and ignored in_valid pulses
    ready_man = 1'b0;
    @(posedge clk); #1;
    push_model(8'd105, 1'b0);
    send_value(8'd105, 1'b0, 1'b0);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (tx_data !== 8'h31 || tx_valid !== 1'b1 || busy !== 1'b1) stable = 1'b0;
      in_data  = 8'hAA;
      in_last  = 1'b0;
      in_valid = i[0];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("stall_hold", {31'd0, stable}, 32'd1);
    ready_man = 1'b1;
    drain();
    repeat (12) @(posedge clk);
    #1;
    check("no_extra_output", {31'd0, tx_valid}, 32'd0);

    // Reset in SEND_T of 128, then 9 prints cleanly
    push_model(8'd128, 1'b0);
    send_value(8'd128, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("send_t_byte", {24'd0, tx_data}, 32'h32);
    reset = 1'b0;
    #1;
    check("async_drop_valid", {31'd0, tx_valid}, 32'd0);
    check("async_drop_data", {24'd0, tx_data}, 32'h00);
    check("async_drop_busy", {31'd0, busy}, 32'd0);
    byte_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_midreset", {31'd0, in_ready}, 32'd1);
    xs = xfer_cnt;
    push_model(8'd9, 1'b0);
    send_value(8'd9, 1'b0, 1'b0);
    drain();
    check("byte_count_9", xfer_cnt - xs, SUP ? 2 : 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
